pc_unit: RTL

Parametrised program-counter unit for the DLX core: the next generation of the fetch-address register. It adds configurable width and vectors, a hold command, call/return through an internal return-address stack (RAS), trap entry/return with a saved exception PC, and misaligned-target detection. It drives `i_address` to instruction memory and advances only on the write-back strobe `WB`.

---
 rtl/pc_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// pc_unit: program-counter unit for the DLX fetch stage.
// Holds the fetch address and advances it on the write-back strobe. Also
// provides a return-address stack, trap entry with a saved exception PC,
// and rejection of misaligned jump targets.
module pc_unit #(
    parameter int              WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0100),
    parameter int              RAS_DEPTH    = 4
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               WB,
    input  logic [2:0]                         pc_cmd,
    input  logic [WIDTH-1:0]                   pc_v,
    input  logic                               trap,
    output logic [WIDTH-1:0]                   i_address,
    output logic [WIDTH-1:0]                   link,
    output logic [WIDTH-1:0]                   epc,
    output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count,
    output logic                               ras_overflow,
    output logic                               ras_underflow,
    output logic                               misaligned_fault
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    localparam logic [PW-1:0] PTR_MAX    = PW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(RAS_DEPTH);

    localparam logic [2:0] CMD_SEQ   = 3'b000;
    localparam logic [2:0] CMD_HOLD  = 3'b001;
    localparam logic [2:0] CMD_REL   = 3'b010;
    localparam logic [2:0] CMD_ABS   = 3'b011;
    localparam logic [2:0] CMD_CALLR = 3'b100;
    localparam logic [2:0] CMD_CALLA = 3'b101;
    localparam logic [2:0] CMD_RET   = 3'b110;
    localparam logic [2:0] CMD_ERET  = 3'b111;

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    top_ptr;
    logic [PW-1:0]    ptr_next;
    logic [PW-1:0]    ptr_prev;

    logic [WIDTH-1:0] target;
    logic             cmd_push;
    logic             cmd_pop;
    logic             cmd_underflow;
    logic             misaligned;
    logic             ras_empty;
    logic             do_cmd;
    logic             do_push;

    assign i_address = pc;
    assign link      = pc + WIDTH'(4);
    assign ras_empty = (ras_count == '0);

    // top_ptr marks the next free slot; wrap by hand so non-power-of-two depths work
    always_comb begin
        ptr_next = (top_ptr == PTR_MAX) ? '0 : top_ptr + PW'(1);
        ptr_prev = (top_ptr == '0) ? PTR_MAX : top_ptr - PW'(1);
    end

    // Decode the command into a target address and its stack side effects
    always_comb begin
        target        = pc;
        cmd_push      = 1'b0;
        cmd_pop       = 1'b0;
        cmd_underflow = 1'b0;
        case (pc_cmd)
            CMD_SEQ:   target = link;
            CMD_HOLD:  target = pc;
            CMD_REL:   target = pc + pc_v;
            CMD_ABS:   target = pc_v;
            CMD_CALLR: begin
                target   = pc + pc_v;
                cmd_push = 1'b1;
            end
            CMD_CALLA: begin
                target   = pc_v;
                cmd_push = 1'b1;
            end
            CMD_RET: begin
                if (!ras_empty) begin
                    target  = ras_mem[ptr_prev];
                    cmd_pop = 1'b1;
                end else begin
                    target        = pc_v;
                    cmd_underflow = 1'b1;
                end
            end
            CMD_ERET:  target = epc;
            default:   target = pc;
        endcase
        misaligned = (pc_cmd[2] | pc_cmd[1]) && (target[1:0] != 2'b00);
        do_cmd     = WB && !trap && !misaligned;
        do_push    = do_cmd && cmd_push;
    end

    // Stack entries are plain storage; reset only clears pointer and count
    always_ff @(posedge clk) begin
        if (reset_n && do_push) begin
            ras_mem[top_ptr] <= link;
        end
    end

    // PC, EPC, stack bookkeeping and status flags
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc               <= RESET_VECTOR;
            epc              <= '0;
            top_ptr          <= '0;
            ras_count        <= '0;
            ras_overflow     <= 1'b0;
            ras_underflow    <= 1'b0;
            misaligned_fault <= 1'b0;
        end else begin
            ras_underflow    <= 1'b0;
            misaligned_fault <= 1'b0;
            if (WB) begin
                if (trap) begin
                    epc <= pc;
                    pc  <= TRAP_VECTOR;
                end else if (misaligned) begin
                    epc              <= pc;
                    pc               <= TRAP_VECTOR;
                    misaligned_fault <= 1'b1;
                end else begin
                    pc <= target;
                    if (cmd_push) begin
                        top_ptr <= ptr_next;
                        if (ras_count == COUNT_FULL) begin
                            ras_overflow <= 1'b1;
                        end else begin
                            ras_count <= ras_count + CW'(1);
                        end
                    end
                    if (cmd_pop) begin
                        top_ptr   <= ptr_prev;
                        ras_count <= ras_count - CW'(1);
                    end
                    if (cmd_underflow) begin
                        ras_underflow <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
